// File: rtl/seq_ctrl_pkg.sv
// Shared state encoding and default sizing for the serial pattern detector.
package seq_ctrl_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Serial history shift register, fill counter and length-masked pattern compare.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             accept,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             hit
);

    logic [PAT_W-1:0] hist, hist_nxt, mask;
    logic [LEN_W-1:0] fill, fill_nxt;

    always_comb begin
        hist_nxt = (hist << 1) | PAT_W'(bit_in);
        fill_nxt = (fill >= len) ? len : fill + LEN_W'(1);
        mask     = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (LEN_W'(i) < len);
        hit = accept && (fill_nxt == len) && ((hist_nxt & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (accept) begin
            hist <= hist_nxt;
            // non-overlapping mode restarts the window after every match
            fill <= (hit && !overlap) ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: config latch, FSM, match counter.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_max,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] max_q;
    logic             len_ok, accept, clr, hit;
    logic [CNT_W-1:0] cnt_nxt;

    assign len_ok   = (len_q != '0) && (len_q <= LEN_W'(PAT_W));
    assign in_ready = (state == RUN) && !abort;
    assign accept   = in_valid && in_ready;
    assign clr      = (state == IDLE) && start && len_ok;
    assign cnt_nxt  = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    seq_match_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .accept  (accept),
        .bit_in  (in_bit),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            max_q     <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
            err       <= 1'b0;
        end else begin
            match <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ovl_q <= cfg_overlap;
                        max_q <= cfg_max;
                    end
                    // start checks the already-latched length, not a same-cycle write
                    if (start) begin
                        if (len_ok) begin
                            match_cnt <= '0;
                            state     <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (hit) begin
                        match     <= 1'b1;
                        match_cnt <= cnt_nxt;
                        if ((max_q != '0) && (cnt_nxt == max_q))
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of the match counter and match target.
REQ-003 Parameter LEN_W, default 4: width of cfg_len; SHALL satisfy 2**LEN_W > PAT_W.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is received first, bit 0 last.
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches, 0 = history restarts after each match.
- cfg_max  in  CNT_W  match target; 0 = unlimited.
- start  in  1  pulse that arms a detection run.
- abort  in  1  stops a run.
- in_valid  in  1  serial bit valid.
- in_bit  in  1  serial data bit.
- in_ready  out  1  bit accepted when in_valid & in_ready.
- match  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  matches in the current or last run.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the target is reached.
- err  out  1  one-cycle pulse on start with an illegal cfg_len.

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-006 In IDLE, cfg_we SHALL latch cfg_pattern, cfg_len, cfg_overlap and cfg_max; cfg_we SHALL be ignored in RUN and DONE.
REQ-007 In IDLE, start with latched len in 1..PAT_W SHALL do all of: clear match_cnt, clear the history and its fill count, and enter RUN on the next edge.
REQ-008 In IDLE, start with latched len of 0 or greater than PAT_W SHALL pulse err for one cycle and remain in IDLE.
REQ-009 start SHALL be ignored in RUN and DONE.
REQ-010 in_ready SHALL equal (state==RUN) & ~abort, combinationally.
REQ-011 Each accepted bit SHALL shift into the LSB of a PAT_W-bit history register; the fill count SHALL increment and saturate at len.
REQ-012 A match SHALL occur on an accepted bit when the new fill count equals len and the new history[len-1:0] equals pattern[len-1:0].
REQ-013 On a match, match SHALL be 1 for exactly the cycle following the accepting edge.
REQ-014 On a match, match_cnt SHALL increment on that same edge and saturate at 2**CNT_W-1.
REQ-015 On a match with cfg_overlap=0, the fill count SHALL reset to 0; with cfg_overlap=1 it SHALL be retained.
REQ-016 When a match makes match_cnt equal a nonzero cfg_max, the FSM SHALL enter DONE on the same edge.
REQ-017 done SHALL equal (state==DONE); DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-018 abort in RUN SHALL return the FSM to IDLE on the next edge, with no done and match_cnt held; abort in IDLE or DONE SHALL have no effect.
REQ-019 When abort and in_valid are both high in RUN, abort SHALL win: the bit is not accepted and no match occurs.
REQ-020 With cfg_max=0, RUN SHALL continue until abort.
REQ-021 match_cnt SHALL hold its value in IDLE and DONE until the next legal start.
REQ-022 busy SHALL equal (state==RUN).

Reset
REQ-023 Assertion of rst (low) SHALL asynchronously force all of the following: state IDLE; history, fill count and match_cnt to 0; latched pattern, len, overlap and max to 0; match, done, err and busy to 0.
REQ-024 Reset asserted mid-run SHALL discard the partial history; a start after release SHALL give err until a new cfg_we, because len resets to 0.

Structure
REQ-025 Package seq_ctrl_pkg SHALL hold the state enumeration and the default PAT_W, CNT_W and LEN_W constants.
REQ-026 The history register, fill count and masked compare SHALL live in one sub-module, seq_match_core; the FSM, configuration registers and counter SHALL live in the top module.

Verification
REQ-027 Config pattern=4'b0101, len=4, overlap=1, max=0; start; stream 0,1,0,1,0,1,0,1 -> match pulses after bits 4, 6 and 8; match_cnt=3; no done.
REQ-028 Same stream with overlap=0 -> match pulses after bits 4 and 8 only; match_cnt=2.
REQ-029 Config pattern 0101, len=4, overlap=1, max=2; start; stream 01010101 -> done pulses with the second match; FSM in IDLE the next cycle; bits 7-8 refused (in_ready=0); match_cnt=2.
REQ-030 Start with len=0 and with len=9 (PAT_W=8) -> one-cycle err pulse each; busy stays 0; match_cnt unchanged.
REQ-031 Abort on the same cycle as the bit that would complete a match -> no match pulse; match_cnt unchanged; state IDLE next cycle; cfg_we accepted afterwards.
REQ-032 Assert rst mid-run after 3 bits of 0101 -> all outputs 0 immediately; after release, start gives err until reconfigured.
